// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD transaction layer: operation codes, HD44780 instruction
// constants, FSM state enum and the operation-to-byte mapping helper.
package lcd_pkg;

    localparam logic [1:0] OP_WRITE_CHAR = 2'd0;
    localparam logic [1:0] OP_CLEAR      = 2'd1;
    localparam logic [1:0] OP_SET_CURSOR = 2'd2;
    localparam logic [1:0] OP_RAW_CMD    = 2'd3;

    localparam logic [7:0] LCD_CLEAR  = 8'h01;
    localparam logic [7:0] DDRAM_BASE = 8'h80;
    localparam logic [7:0] LINE2_OFS  = 8'h40;

    typedef enum logic [2:0] {
        ST_INIT_REQ,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SEND,
        ST_SEND_WAIT,
        ST_WRAP_SEND,
        ST_WRAP_WAIT
    } lcd_state_e;

    // Returns {rs, byte} for an operation; rs=1 only for character data.
    function automatic logic [8:0] map_cmd(input logic [1:0] op, input logic [7:0] data);
        logic [8:0] r;
        case (op)
            OP_WRITE_CHAR: r = {1'b1, data};
            OP_CLEAR:      r = {1'b0, LCD_CLEAR};
            OP_SET_CURSOR: r = {1'b0, DDRAM_BASE | (data[4] ? LINE2_OFS : 8'h00) | {4'h0, data[3:0]}};
            default:       r = {1'b0, data};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_done_timer.sv
// Clearable wait counter: counts while run is high, flags expiry on the DONE_TIMEOUT-th cycle.
module lcd_done_timer #(
    parameter int DONE_TIMEOUT = 1000000,
    parameter int TMR_W        = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(DONE_TIMEOUT - 1);

    logic [TMR_W-1:0] count;

    // Dropping run between WAIT states restarts the count on every entry.
    always_ff @(posedge clk) begin
        if (!reset || !run)
            count <= '0;
        else if (count != LAST)
            count <= count + 1'b1;
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/lcd_transaction.sv
// LCD transaction layer: power-up init, then operation -> {byte, RS} with phy handshakes.
// Optional cursor auto-wrap at column 16 enabled by defining LCD_TRANSACTION_AUTOWRAP_EN.
module lcd_transaction
    import lcd_pkg::*;
#(
    parameter int DONE_TIMEOUT = 1000000,
    parameter int TMR_W        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    input  logic       init_done,
    input  logic       send_data_done,
    output logic       do_init,
    output logic       do_send_data,
    output logic [7:0] data_to_send,
    output logic       lcdrs_in,
    output logic       busy,
    output logic       timeout_err
);

    lcd_state_e state, state_next;
    logic       tmr_run, tmr_expired, wait_done;
    logic [8:0] mapped;

    assign mapped    = map_cmd(cmd_op, cmd_data);
    assign tmr_run   = (state == ST_INIT_WAIT) || (state == ST_SEND_WAIT) || (state == ST_WRAP_WAIT);
    assign wait_done = ((state == ST_INIT_WAIT) && init_done) ||
                       (((state == ST_SEND_WAIT) || (state == ST_WRAP_WAIT)) && send_data_done);

`ifdef LCD_TRANSACTION_AUTOWRAP_EN
    logic [4:0] column;
    logic       line;
    logic [1:0] op_q;
    logic [7:0] arg_q;
    logic       wrap_needed;

    assign wrap_needed = (cmd_op == OP_WRITE_CHAR) && (column == 5'd16);
`endif

    lcd_done_timer #(
        .DONE_TIMEOUT (DONE_TIMEOUT),
        .TMR_W        (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_INIT_REQ;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT_REQ:  state_next = ST_INIT_WAIT;
            ST_INIT_WAIT: if (init_done || tmr_expired) state_next = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
`ifdef LCD_TRANSACTION_AUTOWRAP_EN
                    state_next = wrap_needed ? ST_WRAP_SEND : ST_SEND;
`else
                    state_next = ST_SEND;
`endif
                end
            end
            ST_SEND:      state_next = ST_SEND_WAIT;
            ST_SEND_WAIT: if (send_data_done || tmr_expired) state_next = ST_IDLE;
`ifdef LCD_TRANSACTION_AUTOWRAP_EN
            ST_WRAP_SEND: state_next = ST_WRAP_WAIT;
            ST_WRAP_WAIT: begin
                if (send_data_done)
                    state_next = ST_SEND;
                else if (tmr_expired)
                    state_next = ST_IDLE;
            end
`endif
            default:      state_next = ST_INIT_REQ;
        endcase
    end

    always_comb begin
        cmd_ready    = (state == ST_IDLE);
        busy         = (state != ST_IDLE);
        do_send_data = (state == ST_SEND) || (state == ST_WRAP_SEND);
    end

    // do_init is registered so it stays low while reset holds the FSM in INIT_REQ.
    always_ff @(posedge clk) begin
        if (!reset) begin
            do_init      <= 1'b0;
            data_to_send <= 8'h00;
            lcdrs_in     <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef LCD_TRANSACTION_AUTOWRAP_EN
            column       <= 5'd0;
            line         <= 1'b0;
            op_q         <= OP_WRITE_CHAR;
            arg_q        <= 8'h00;
`endif
        end else begin
            do_init <= (state == ST_INIT_REQ);
            if (tmr_expired && !wait_done)
                timeout_err <= 1'b1;
            if ((state == ST_IDLE) && cmd_valid) begin
                data_to_send <= mapped[7:0];
                lcdrs_in     <= mapped[8];
`ifdef LCD_TRANSACTION_AUTOWRAP_EN
                op_q  <= cmd_op;
                arg_q <= cmd_data;
                if (wrap_needed) begin
                    data_to_send <= line ? DDRAM_BASE : (DDRAM_BASE | LINE2_OFS);
                    lcdrs_in     <= 1'b0;
                end
`endif
            end
`ifdef LCD_TRANSACTION_AUTOWRAP_EN
            // Cursor moved to the other line's start; now emit the held character.
            if ((state == ST_WRAP_WAIT) && send_data_done) begin
                data_to_send <= arg_q;
                lcdrs_in     <= 1'b1;
                line         <= ~line;
                column       <= 5'd0;
            end
            if ((state == ST_SEND_WAIT) && send_data_done) begin
                case (op_q)
                    OP_WRITE_CHAR: column <= column + 5'd1;
                    OP_CLEAR: begin
                        column <= 5'd0;
                        line   <= 1'b0;
                    end
                    OP_SET_CURSOR: begin
                        column <= {1'b0, arg_q[3:0]};
                        line   <= arg_q[4];
                    end
                    default: ;
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_transaction.sv
// Self-checking bench for lcd_transaction: vector table, hand-written corner sequences and
// randomized operations against a cursor/byte reference model (also models LCD_TRANSACTION_AUTOWRAP_EN).
module tb_lcd_transaction;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       init_done = 1'b0;
    logic       send_data_done = 1'b0;
    logic       do_init;
    logic       do_send_data;
    logic [7:0] data_to_send;
    logic       lcdrs_in;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int m_col    = 0;
    int m_line   = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] d;
        logic [7:0] b;
        logic       rs;
    } vec_t;

    vec_t vecs[10];

    lcd_transaction #(
        .DONE_TIMEOUT (8),
        .TMR_W        (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .init_done      (init_done),
        .send_data_done (send_data_done),
        .do_init        (do_init),
        .do_send_data   (do_send_data),
        .data_to_send   (data_to_send),
        .lcdrs_in       (lcdrs_in),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference mapping from the operation rules, in plain arithmetic.
    function automatic logic [8:0] model_byte(input int op, input int d);
        int b;
        int rs;
        rs = 0;
        case (op)
            0: begin b = d; rs = 1; end
            1: b = 1;
            2: b = 128 + ((d / 16) % 2) * 64 + (d % 16);
            default: b = d;
        endcase
        return {rs[0], b[7:0]};
    endfunction

    task automatic reset_init(input bit init_tmo);
        reset = 1'b0; cmd_valid = 1'b0; init_done = 1'b0; send_data_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_ready", cmd_ready, 0);
        check("rst_do_init", do_init, 0);
        check("rst_do_send", do_send_data, 0);
        check("rst_data", data_to_send, 8'h00);
        check("rst_rs", lcdrs_in, 0);
        check("rst_err", timeout_err, 0);
        m_col = 0; m_line = 0;
        reset = 1'b1;
        @(negedge clk);
        check("init_pulse", do_init, 1);
        if (init_tmo) begin
            repeat (8) @(negedge clk);
            check("init_tmo_ready", cmd_ready, 1);
            check("init_tmo_err", timeout_err, 1);
        end else begin
            @(negedge clk);
            check("init_pulse_width", do_init, 0);
            send_data_done = 1'b1;
            @(negedge clk);
            send_data_done = 1'b0;
            check("init_stray_busy", busy, 1);
            init_done = 1'b1;
            @(negedge clk);
            init_done = 1'b0;
            check("init_ready", cmd_ready, 1);
            check("init_busy", busy, 0);
            check("init_err", timeout_err, 0);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] eb,
                          input logic ers, input int delay);
        logic [8:0] q[$];
        bit wrapped;
        wrapped = 1'b0;
`ifdef LCD_TRANSACTION_AUTOWRAP_EN
        if (op == 2'd0 && m_col == 16) begin
            q.push_back({1'b0, (m_line != 0) ? 8'h80 : 8'hC0});
            wrapped = 1'b1;
        end
`endif
        q.push_back({ers, eb});
        check("ready_before", cmd_ready, 1);
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        foreach (q[i]) begin
            check("send_pulse", do_send_data, 1);
            check("send_byte", data_to_send, {24'h0, q[i][7:0]});
            check("send_rs", lcdrs_in, {31'h0, q[i][8]});
            @(negedge clk);
            check("send_pulse_width", do_send_data, 0);
            for (int k = 0; k < delay; k++) @(negedge clk);
            check("send_byte_hold", data_to_send, {24'h0, q[i][7:0]});
            send_data_done = 1'b1;
            @(negedge clk);
            send_data_done = 1'b0;
        end
        check("ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
        check("byte_idle_hold", data_to_send, {24'h0, eb});
        if (wrapped) begin
            m_line = 1 - m_line;
            m_col = 0;
        end
        case (op)
            2'd0: m_col++;
            2'd1: begin m_col = 0; m_line = 0; end
            2'd2: begin m_col = d % 16; m_line = (d / 16) % 2; end
            default: ;
        endcase
    endtask

    initial begin
        logic [8:0] mb;
        logic [1:0] rop;
        logic [7:0] rd;

        vecs[0] = '{2'd0, 8'h41, 8'h41, 1'b1};
        vecs[1] = '{2'd2, 8'h1A, 8'hCA, 1'b0};
        vecs[2] = '{2'd1, 8'h00, 8'h01, 1'b0};
        vecs[3] = '{2'd3, 8'h38, 8'h38, 1'b0};
        vecs[4] = '{2'd2, 8'hFF, 8'hCF, 1'b0};
        vecs[5] = '{2'd2, 8'hE0, 8'h80, 1'b0};
        vecs[6] = '{2'd0, 8'h00, 8'h00, 1'b1};
        vecs[7] = '{2'd3, 8'hFF, 8'hFF, 1'b0};
        vecs[8] = '{2'd2, 8'h13, 8'hC3, 1'b0};
        vecs[9] = '{2'd1, 8'hAA, 8'h01, 1'b0};

        reset_init(1'b0);
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].d, vecs[i].b, vecs[i].rs, i % 4);

        // Stray done pulse in IDLE must not start anything.
        send_data_done = 1'b1;
        @(negedge clk);
        send_data_done = 1'b0;
        check("stray_idle_send", do_send_data, 0);
        check("stray_idle_ready", cmd_ready, 1);

        // Done pulse on the timeout cycle wins.
        cmd_op = 2'd3; cmd_data = 8'h0C; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("late_pulse", do_send_data, 1);
        repeat (8) @(negedge clk);
        check("late_busy", busy, 1);
        send_data_done = 1'b1;
        @(negedge clk);
        send_data_done = 1'b0;
        check("late_ready", cmd_ready, 1);
        check("late_no_err", timeout_err, 0);

        // Withheld done: error after 8 wait cycles, back to IDLE.
        cmd_op = 2'd3; cmd_data = 8'h06; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("tmo_pulse", do_send_data, 1);
        repeat (8) @(negedge clk);
        check("tmo_busy_last", busy, 1);
        check("tmo_err_pending", timeout_err, 0);
        @(negedge clk);
        check("tmo_ready", cmd_ready, 1);
        check("tmo_err", timeout_err, 1);
        run_op(2'd0, 8'h42, 8'h42, 1'b1, 1);
        check("tmo_err_sticky", timeout_err, 1);

        // Reset while in SEND_WAIT abandons the operation.
        cmd_op = 2'd0; cmd_data = 8'h55; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1);
        check("midrst_ready", cmd_ready, 0);
        check("midrst_send", do_send_data, 0);
        check("midrst_err", timeout_err, 0);
        reset_init(1'b1);
        reset_init(1'b0);

        // Fill a line, then one more character.
        run_op(2'd1, 8'h00, 8'h01, 1'b0, 0);
        for (int i = 0; i < 16; i++)
            run_op(2'd0, 8'h30 + 8'(i), 8'h30 + 8'(i), 1'b1, i % 3);
        run_op(2'd0, 8'h5A, 8'h5A, 1'b1, 2);
        for (int i = 0; i < 16; i++)
            run_op(2'd0, 8'h61 + 8'(i), 8'h61 + 8'(i), 1'b1, 0);
        run_op(2'd0, 8'h7A, 8'h7A, 1'b1, 1);

        for (int i = 0; i < 60; i++) begin
            rop = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            rd  = 8'($urandom_range(0, 255));
            mb  = model_byte(int'(rop), int'(rd));
            run_op(rop, rd, mb[7:0], mb[8], int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
